// File: rtl/rvga_mem_arbiter.sv
// Arbitrates the core's instruction-fetch and data ports onto one single-port memory, one transaction at a time.
// Optional macro RVGA_MEM_ARB_RR_EN switches simultaneous-request arbitration from fixed dmem priority to round-robin.
module rvga_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              imem_v_i,
    input  logic [ADDR_W-1:0] imem_addr_i,
    output logic [DATA_W-1:0] imem_data_o,
    output logic              imem_resp_v_o,
    input  logic              dmem_r_v_i,
    input  logic              dmem_w_v_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_data_i,
    input  logic [MASK_W-1:0] dmem_wmask_i,
    output logic [DATA_W-1:0] dmem_data_o,
    output logic              dmem_resp_v_o,
    output logic              mem_v_o,
    output logic              mem_w_v_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [MASK_W-1:0] mem_wmask_o,
    input  logic              mem_ready_i,
    input  logic              mem_resp_v_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        WAIT_I,
        WAIT_D
    } state_t;

    state_t state;
    state_t state_next;

    logic              dmem_req;
    logic              any_req;
    logic              grant_d;
    logic              capture;

    logic              next_w;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_data;
    logic [MASK_W-1:0] next_mask;

    logic              cap_w;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [MASK_W-1:0] cap_mask;

    assign dmem_req = dmem_r_v_i | dmem_w_v_i;
    assign any_req  = dmem_req | imem_v_i;
    assign capture  = (state == IDLE) && any_req;

`ifdef RVGA_MEM_ARB_RR_EN
    // last_grant: 1 = dmem was served last, 0 = imem was served last
    logic last_grant;

    always_comb begin
        grant_d = dmem_req;
        if (dmem_req && imem_v_i) begin
            grant_d = ~last_grant;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant <= 1'b0;
        end else if (capture) begin
            last_grant <= grant_d;
        end
    end
`else
    always_comb begin
        grant_d = dmem_req;
    end
`endif

    // Request fields for the winner; a simultaneous load/store is issued as the store
    always_comb begin
        next_w    = grant_d & dmem_w_v_i;
        next_addr = grant_d ? dmem_addr_i : imem_addr_i;
        next_data = next_w ? dmem_data_i : '0;
        next_mask = next_w ? dmem_wmask_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = grant_d ? REQ_D : REQ_I;
                end
            end
            REQ_I: begin
                if (mem_ready_i) begin
                    state_next = WAIT_I;
                end
            end
            REQ_D: begin
                if (mem_ready_i) begin
                    state_next = WAIT_D;
                end
            end
            WAIT_I: begin
                if (mem_resp_v_i) begin
                    state_next = IDLE;
                end
            end
            WAIT_D: begin
                if (mem_resp_v_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Fields are frozen from the grant edge until the next grant, so they stay stable while ready is low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_w    <= 1'b0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_mask <= '0;
        end else if (capture) begin
            cap_w    <= next_w;
            cap_addr <= next_addr;
            cap_data <= next_data;
            cap_mask <= next_mask;
        end
    end

    assign mem_v_o     = (state == REQ_I) || (state == REQ_D);
    assign mem_w_v_o   = cap_w;
    assign mem_addr_o  = cap_addr;
    assign mem_data_o  = cap_data;
    assign mem_wmask_o = cap_mask;

    // Responses outside WAIT_x (early, or after a reset) are dropped here
    assign imem_resp_v_o = (state == WAIT_I) && mem_resp_v_i;
    assign dmem_resp_v_o = (state == WAIT_D) && mem_resp_v_i;
    assign imem_data_o   = mem_data_i;
    assign dmem_data_o   = mem_data_i;

endmodule
